trng_capture_ctrl: RTL and testbench

Sequences ring-oscillator entropy capture runs. Collects serial sample bits from two ring-oscillator combiner sources (already synchronized into `clock`) and packs them into words. When both sources are enabled it alternates between them word by word. Packed words go to the downstream debug/readout logic through a valid/ready handshake. Sits between the `ro_comb` sample paths and the capture memory/VIO readout, and replaces the free-running per-clock index counters with one controlled, bounded run.

---
 rtl/trng_capture_ctrl_if.sv | 29 ++
 rtl/trng_capture_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_trng_capture_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trng_capture_ctrl_if.sv
// trng_capture_ctrl_if: packed-word readout handshake between the capture
// controller and the downstream debug/readout logic.
//   word_out   - packed sample word, bit k = k-th accepted sample
//   word_src   - source index the word was taken from
//   word_valid - word available
//   word_ready - consumer accepts the word
// Modports: master (controller side), slave (consumer side).
interface trng_capture_ctrl_if #(
    parameter int unsigned WORD_W = 32
);
    logic [WORD_W-1:0] word_out;
    logic              word_src;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_out,
        output word_src,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_src,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/trng_capture_ctrl.sv
// trng_capture_ctrl: sequences one bounded ring-oscillator entropy capture run.
// Serial sample bits from up to two synchronized sources are packed into
// WORD_W-bit words; with both sources enabled the active source alternates
// word by word. Words leave through a valid/ready handshake.
//
// Ports:
//   clock, cpu_reset      - clock (rising edge), async active-low reset
//   start, abort          - run request (IDLE only) / immediate run end
//   src_sel[1:0]          - source enables, captured at accepted start
//   bit_in0/1, bit_vld0/1 - per-source sample bit and strobe
//   word_bus (master)     - word_out / word_src / word_valid / word_ready
//   word_count            - words handed off in this run
//   busy, done            - run active / one-cycle normal-completion pulse
//   health_fail           - sticky repetition-count failure
//
// Optional feature: define TRNG_HEALTH_EN to build the repetition-count
// health test (REP_LIMIT identical consecutive bits abort the run).
module trng_capture_ctrl #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned SAMPLES   = 256,
    parameter int unsigned REP_LIMIT = 16,
    localparam int unsigned NWORDS   = SAMPLES / WORD_W,
    localparam int unsigned CNT_W    = $clog2(NWORDS) + 1
) (
    input  logic                 clock,
    input  logic                 cpu_reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           src_sel,
    input  logic                 bit_in0,
    input  logic                 bit_in1,
    input  logic                 bit_vld0,
    input  logic                 bit_vld1,
    trng_capture_ctrl_if.master  word_bus,
    output logic [CNT_W-1:0]     word_count,
    output logic                 busy,
    output logic                 done,
    output logic                 health_fail
);
    localparam int unsigned BIT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {StIdle, StFill, StOut} state_e;

    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic              act_q, act_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_q, done_d;

    logic act_vld;
    logic act_bit;
    logic start_ok;
    logic rep_trip;
    logic rep_clr;
    logic hfail_set;
    logic hfail_clr;

    assign act_vld  = act_q ? bit_vld1 : bit_vld0;
    assign act_bit  = act_q ? bit_in1 : bit_in0;
    assign start_ok = start & ~abort & (src_sel != 2'b00);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        act_d     = act_q;
        bit_cnt_d = bit_cnt_q;
        word_d    = word_q;
        count_d   = count_q;
        done_d    = 1'b0;
        rep_clr   = 1'b0;
        hfail_set = 1'b0;
        hfail_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d   = StFill;
                    sel_d     = src_sel;
                    act_d     = ~src_sel[0];  // lowest enabled source first
                    bit_cnt_d = '0;
                    count_d   = '0;
                    rep_clr   = 1'b1;
                    hfail_clr = 1'b1;
                end
            end
            StFill: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (act_vld) begin
                    if (rep_trip) begin
                        state_d   = StIdle;
                        hfail_set = 1'b1;
                    end else begin
                        word_d[bit_cnt_q] = act_bit;
                        bit_cnt_d         = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
                            state_d   = StOut;
                            bit_cnt_d = '0;
                        end
                    end
                end
            end
            StOut: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (word_bus.word_ready) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_d == CNT_W'(NWORDS)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = StFill;
                        bit_cnt_d = '0;
                        if (sel_q == 2'b11) begin
                            act_d   = ~act_q;
                            rep_clr = 1'b1;  // run length is per source
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge cpu_reset) begin
        if (!cpu_reset) begin
            state_q   <= StIdle;
            sel_q     <= 2'b00;
            act_q     <= 1'b0;
            bit_cnt_q <= '0;
            word_q    <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            act_q     <= act_d;
            bit_cnt_q <= bit_cnt_d;
            word_q    <= word_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

`ifdef TRNG_HEALTH_EN
    logic [7:0] rep_cnt_q;
    logic [7:0] rep_next;
    logic       rep_bit_q;
    logic       hfail_q;
    logic       accept;

    // Abort takes priority, so a bit seen in an abort cycle is not counted.
    assign accept   = (state_q == StFill) & act_vld & ~abort;
    assign rep_next = (rep_cnt_q != 8'd0 && act_bit == rep_bit_q) ? rep_cnt_q + 8'd1 : 8'd1;
    assign rep_trip = accept & (rep_next == 8'(REP_LIMIT));

    always_ff @(posedge clock or negedge cpu_reset) begin
        if (!cpu_reset) begin
            rep_cnt_q <= 8'd0;
            rep_bit_q <= 1'b0;
            hfail_q   <= 1'b0;
        end else begin
            if (rep_clr) begin
                rep_cnt_q <= 8'd0;
            end else if (accept) begin
                rep_cnt_q <= rep_next;
                rep_bit_q <= act_bit;
            end
            if (hfail_clr) begin
                hfail_q <= 1'b0;
            end else if (hfail_set) begin
                hfail_q <= 1'b1;
            end
        end
    end

    assign health_fail = hfail_q;
`else
    logic unused_health;
    assign unused_health = ^{rep_clr, hfail_set, hfail_clr};
    assign rep_trip      = 1'b0;
    assign health_fail   = 1'b0;
`endif

    assign word_bus.word_out   = word_q;
    assign word_bus.word_src   = act_q;
    assign word_bus.word_valid = (state_q == StOut);
    assign word_count          = count_q;
    assign busy                = (state_q != StIdle);
    assign done                = done_q;
endmodule

// File: tb/tb_trng_capture_ctrl.sv
// Self-checking bench for trng_capture_ctrl: a transaction-level model
// (bit queue per word, word/handshake counts) is compared with the DUT
// every cycle, plus literal expectations for the directed scenarios.
module tb_trng_capture_ctrl;
    localparam int WORD_W    = 32;
    localparam int SAMPLES   = 256;
    localparam int REP_LIMIT = 16;
    localparam int NWORDS    = SAMPLES / WORD_W;
    localparam int CW        = $clog2(NWORDS) + 1;
`ifdef TRNG_HEALTH_EN
    localparam bit HEALTH = 1'b1;
`else
    localparam bit HEALTH = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          cpu_reset;
    logic          start, abort;
    logic [1:0]    src_sel;
    logic          bit_in0, bit_in1, bit_vld0, bit_vld1;
    logic [CW-1:0] word_count;
    logic          busy, done, health_fail;

    trng_capture_ctrl_if #(.WORD_W(WORD_W)) bus ();

    trng_capture_ctrl #(
        .WORD_W   (WORD_W),
        .SAMPLES  (SAMPLES),
        .REP_LIMIT(REP_LIMIT)
    ) dut (
        .clock      (clock),
        .cpu_reset  (cpu_reset),
        .start      (start),
        .abort      (abort),
        .src_sel    (src_sel),
        .bit_in0    (bit_in0),
        .bit_in1    (bit_in1),
        .bit_vld0   (bit_vld0),
        .bit_vld1   (bit_vld1),
        .word_bus   (bus),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .health_fail(health_fail)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_run, m_have, m_src, m_done, m_hf, m_rep_bit;
    bit          m_q[$];
    logic [31:0] m_word;
    logic [1:0]  m_sel;
    int          m_cnt, m_rep_len;
    int          acc[2];

    task automatic model_reset();
        m_run = 0; m_have = 0; m_src = 0; m_done = 0; m_hf = 0; m_rep_bit = 0;
        m_q.delete(); m_word = '0; m_sel = 2'b00; m_cnt = 0; m_rep_len = 0;
        acc[0] = 0; acc[1] = 0;
    endtask

    task automatic model_step();
        bit v, b;
        m_done = 0;
        if (!m_run) begin
            if (start && !abort && src_sel != 2'b00) begin
                m_run = 1; m_have = 0; m_q.delete(); m_src = !src_sel[0];
                m_cnt = 0; m_hf = 0; m_rep_len = 0; m_sel = src_sel;
                acc[0] = 0; acc[1] = 0;
            end
        end else if (abort) begin
            m_run = 0; m_have = 0; m_q.delete();
        end else if (m_have) begin
            if (bus.word_ready) begin
                m_cnt++;
                m_have = 0;
                if (m_cnt == NWORDS) begin
                    m_run = 0; m_done = 1;
                end else if (m_sel == 2'b11) begin
                    m_src = !m_src; m_rep_len = 0;
                end
            end
        end else begin
            v = m_src ? bit_vld1 : bit_vld0;
            b = m_src ? bit_in1 : bit_in0;
            if (v) begin
                if (m_rep_len > 0 && b == m_rep_bit) m_rep_len++;
                else m_rep_len = 1;
                m_rep_bit = b;
                if (HEALTH && m_rep_len == REP_LIMIT) begin
                    m_hf = 1; m_run = 0; m_q.delete();
                end else begin
                    m_q.push_back(b);
                    acc[int'(m_src)]++;
                    if (m_q.size() == WORD_W) begin
                        for (int i = 0; i < WORD_W; i++) m_word[i] = m_q[i];
                        m_q.delete();
                        m_have = 1;
                    end
                end
            end
        end
    endtask

    always @(posedge clock or negedge cpu_reset) begin
        if (!cpu_reset) model_reset();
        else model_step();
    end

    // ---------------- compare process ----------------
    bit          cmp_en = 0;
    logic [31:0] hs_words[$];
    bit          hs_srcs[$];
    int          done_cnt = 0;

    always @(negedge clock) begin
        if (cmp_en && cpu_reset) begin
            check("busy", busy, m_run);
            check("word_valid", bus.word_valid, m_run && m_have);
            check("done", done, m_done);
            check("health_fail", health_fail, m_hf);
            check("word_count", word_count, m_cnt);
            if (m_run && m_have) begin
                check("word_out", bus.word_out, m_word);
                check("word_src", bus.word_src, m_src);
            end
            if (bus.word_valid && bus.word_ready) begin
                hs_words.push_back(bus.word_out);
                hs_srcs.push_back(bus.word_src);
            end
            if (done) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    int pmode = 0;  // 0: 1010 / 0110 patterns, 1: constant ones, 2: random
    bit rvld  = 0;  // random strobes

    task automatic cycle();
        @(posedge clock);
        #1;
        unique case (pmode)
            0: begin
                bit_in0 = (acc[0] % 2 == 0);
                bit_in1 = (acc[1] % 4 == 1) || (acc[1] % 4 == 2);
            end
            1: begin
                bit_in0 = 1'b1;
                bit_in1 = 1'b1;
            end
            default: begin
                bit_in0 = 1'($urandom);
                bit_in1 = 1'($urandom);
            end
        endcase
        bit_vld0 = rvld ? 1'($urandom) : 1'b1;
        bit_vld1 = rvld ? 1'($urandom) : 1'b1;
    endtask

    task automatic start_run(input logic [1:0] sel);
        start = 1'b1; src_sel = sel;
        cycle();
        start = 1'b0;
    endtask

    task automatic clear_logs();
        hs_words.delete(); hs_srcs.delete(); done_cnt = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin cycle(); n++; end
        check("wait_idle_timeout", busy, 1'b0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.word_valid && n < budget) begin cycle(); n++; end
        check("wait_valid_timeout", bus.word_valid, 1'b1);
    endtask

    task automatic wait_count(input int k, input int budget);
        int n = 0;
        while (int'(word_count) != k && n < budget) begin cycle(); n++; end
        check("wait_count_timeout", word_count, k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        model_reset();
        cpu_reset = 1'b0; start = 0; abort = 0; src_sel = 2'b00;
        bit_in0 = 0; bit_in1 = 0; bit_vld0 = 0; bit_vld1 = 0;
        bus.word_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_word_out", bus.word_out, 0);
        check("rst_word_src", bus.word_src, 0);
        check("rst_word_valid", bus.word_valid, 0);
        check("rst_word_count", word_count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_health_fail", health_fail, 0);
        cpu_reset = 1'b1;
        cmp_en = 1;
        cycle();

        // Single source, alternating bits -> 0x55555555 words.
        clear_logs();
        pmode = 0; rvld = 0; bus.word_ready = 1'b1;
        start_run(2'b01);
        check("t1_busy_after_start", busy, 1);
        wait_idle(400);
        cycle();
        check("t1_nwords", hs_words.size(), NWORDS);
        foreach (hs_words[i]) check("t1_word", hs_words[i], 32'h5555_5555);
        foreach (hs_srcs[i]) check("t1_src", hs_srcs[i], 0);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_word_count", word_count, NWORDS);

        // Both sources: words alternate 0,1,0,...
        clear_logs();
        start_run(2'b11);
        wait_idle(400);
        cycle();
        check("t2_nwords", hs_words.size(), NWORDS);
        foreach (hs_srcs[i]) begin
            check("t2_src", hs_srcs[i], i % 2);
            check("t2_word", hs_words[i], (i % 2 == 0) ? 32'h5555_5555 : 32'h6666_6666);
        end
        check("t2_done_pulses", done_cnt, 1);

        // Backpressure: hold word_ready low for 20 cycles in OUT.
        clear_logs();
        bus.word_ready = 1'b0;
        start_run(2'b01);
        wait_valid(100);
        held = bus.word_out;
        repeat (20) cycle();
        check("t3_stable", bus.word_out, held);
        check("t3_word", held, 32'h5555_5555);
        bus.word_ready = 1'b1;
        wait_idle(400);
        cycle();
        check("t3_nwords", hs_words.size(), NWORDS);
        foreach (hs_words[i]) check("t3_words", hs_words[i], 32'h5555_5555);

        // Abort mid-fill after three words.
        clear_logs();
        start_run(2'b01);
        wait_count(3, 200);
        repeat (5) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("t4_busy_after_abort", busy, 0);
        cycle();
        check("t4_word_count", word_count, 3);
        check("t4_no_done", done_cnt, 0);
        start = 1'b1; abort = 1'b1; src_sel = 2'b01;
        cycle();
        start = 1'b0; abort = 1'b0;
        cycle();
        check("t4_start_abort_busy", busy, 0);

        // Repetition-count health test with a constant-1 source.
        clear_logs();
        pmode = 1;
        start_run(2'b01);
`ifdef TRNG_HEALTH_EN
        wait_idle(60);
        cycle();
        check("t5_health_fail", health_fail, 1);
        check("t5_no_done", done_cnt, 0);
        check("t5_word_count", word_count, 0);
        pmode = 0;
        start_run(2'b01);
        check("t5_hf_cleared", health_fail, 0);
`else
        repeat (40) cycle();
        check("t5_health_tied", health_fail, 0);
        check("t5_still_busy", busy, 1);
        pmode = 0;
`endif
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        cycle();

        // Reset mid-OUT, then a start with no sources enabled.
        bus.word_ready = 1'b0;
        start_run(2'b10);
        wait_valid(100);
        #1;
        cpu_reset = 1'b0;
        #1;
        check("t6_rst_valid", bus.word_valid, 0);
        check("t6_rst_word_out", bus.word_out, 0);
        check("t6_rst_word_src", bus.word_src, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_count", word_count, 0);
        check("t6_rst_done", done, 0);
        cycle();
        cpu_reset = 1'b1;
        bus.word_ready = 1'b1;
        start_run(2'b00);
        cycle();
        check("t6_sel0_busy", busy, 0);

        // Randomized phase, checked cycle by cycle against the model.
        pmode = 2; rvld = 1;
        for (int c = 0; c < 3000; c++) begin
            start          = ($urandom_range(0, 7) == 0);
            src_sel        = 2'($urandom);
            abort          = ($urandom_range(0, 99) == 0);
            bus.word_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        start = 1'b0;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        cycle();
        check("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
